mor1kx_cfgrs_spr_responder: RTL

SPR-bus responder for the group-0 configuration/version registers. It sits on the mor1kx SPR bus between the control unit (initiator) and the configuration-word generator. It decodes group-0 addresses 0–10 and returns the matching read-only word through a stb/ack handshake with programmable latency. Writes to these addresses are acknowledged, discarded and counted.

---
 rtl/mor1kx_cfgrs_spr_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mor1kx_cfgrs_spr_responder.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_cfgrs_spr_responder
// Purpose  : SPR-bus responder returning group-0 configuration words (0-10).
// Revision : 1.0
// ============================================================================
module mor1kx_cfgrs_spr_responder #(
    parameter int OPTION_SPR_LATENCY     = 1,
    parameter     FEATURE_RO_WRITE_COUNT = "ENABLED"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] spr_bus_addr_i,
    input  logic        spr_bus_we_i,
    input  logic        spr_bus_stb_i,
    input  logic [31:0] spr_bus_dat_i,
    output logic [31:0] spr_bus_dat_o,
    output logic        spr_bus_ack_o,
    input  logic [31:0] spr_vr,
    input  logic [31:0] spr_upr,
    input  logic [31:0] spr_cpucfgr,
    input  logic [31:0] spr_dmmucfgr,
    input  logic [31:0] spr_immucfgr,
    input  logic [31:0] spr_dccfgr,
    input  logic [31:0] spr_iccfgr,
    input  logic [31:0] spr_dcfgr,
    input  logic [31:0] spr_pccfgr,
    input  logic [31:0] spr_vr2,
    input  logic [31:0] spr_avr,
    output logic        ro_wr_err_o,
    output logic [7:0]  ro_wr_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] C_LOAD = 2'(OPTION_SPR_LATENCY - 1);

    state_t      state_q;
    logic [1:0]  lat_cnt_q;
    logic [3:0]  idx_q;
    logic        we_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        err_q;

    logic        sel_d;
    logic [3:0]  idx_d;
    logic        we_d;
    logic        ack_d;
    logic [31:0] rd_word_d;

    // Write data is never stored; reduce it so it is visibly consumed.
    logic        unused_dat;
    assign unused_dat = ^spr_bus_dat_i;

    assign sel_d = spr_bus_stb_i && (spr_bus_addr_i[15:11] == 5'd0)
                   && (spr_bus_addr_i[10:0] <= 11'd10);

    // With zero extra latency ACK is entered straight from IDLE, so the live
    // bus fields are used instead of the captured ones.
    assign idx_d = (state_q == ST_IDLE) ? spr_bus_addr_i[3:0] : idx_q;
    assign we_d  = (state_q == ST_IDLE) ? spr_bus_we_i        : we_q;

    assign ack_d = ((state_q == ST_IDLE) && sel_d && (C_LOAD == 2'd0))
                || ((state_q == ST_WAIT) && spr_bus_stb_i && (lat_cnt_q == 2'd1));

    always_comb begin
        rd_word_d = 32'd0;
        case (idx_d)
            4'd0:    rd_word_d = spr_vr;
            4'd1:    rd_word_d = spr_upr;
            4'd2:    rd_word_d = spr_cpucfgr;
            4'd3:    rd_word_d = spr_dmmucfgr;
            4'd4:    rd_word_d = spr_immucfgr;
            4'd5:    rd_word_d = spr_dccfgr;
            4'd6:    rd_word_d = spr_iccfgr;
            4'd7:    rd_word_d = spr_dcfgr;
            4'd8:    rd_word_d = spr_pccfgr;
            4'd9:    rd_word_d = spr_vr2;
            4'd10:   rd_word_d = spr_avr;
            default: rd_word_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= 2'd0;
            idx_q     <= 4'd0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= (ack_d && !we_d) ? rd_word_d : 32'd0;
            err_q <= ack_d && we_d;
            case (state_q)
                ST_IDLE: begin
                    if (sel_d) begin
                        idx_q     <= spr_bus_addr_i[3:0];
                        we_q      <= spr_bus_we_i;
                        lat_cnt_q <= C_LOAD;
                        state_q   <= (C_LOAD == 2'd0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!spr_bus_stb_i) begin
                        lat_cnt_q <= 2'd0;
                        state_q   <= ST_IDLE;
                    end else if (lat_cnt_q == 2'd1) begin
                        lat_cnt_q <= 2'd0;
                        state_q   <= ST_ACK;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (!spr_bus_stb_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spr_bus_ack_o = ack_q;
    assign spr_bus_dat_o = dat_q;
    assign ro_wr_err_o   = err_q;

    generate
        if (FEATURE_RO_WRITE_COUNT == "NONE") begin : g_no_wr_cnt
            assign ro_wr_cnt_o = 8'd0;
        end else begin : g_wr_cnt
            logic [7:0] wr_cnt_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_cnt_q <= 8'd0;
                end else if (ack_d && we_d && (wr_cnt_q != 8'hFF)) begin
                    wr_cnt_q <= wr_cnt_q + 8'd1;
                end
            end
            assign ro_wr_cnt_o = wr_cnt_q;
        end
    endgenerate

endmodule
`default_nettype wire
